// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with single-cycle logic ops and iterative mul/div/mod
//
// Purpose:
//   Accepts an opcode and two unsigned operands on start. Add, sub, bitwise and
//   shift ops complete at the launch edge. Mul (shift-add) and div/mod
//   (restoring division) take one step per cycle for N cycles.
//
// Ports:
//   clk    - system clock, all state on rising edge
//   rst_n  - asynchronous active-low reset
//   start  - launch request, honoured whenever busy is low
//   sel    - opcode (add, sub, mul, div, mod, or, and, xor, shl, shr)
//   aIn    - operand A
//   bIn    - operand B
//   busy   - multi-cycle operation in progress, start ignored
//   done   - one-cycle pulse, cOut/Flags just updated
//   cOut   - registered result
//   Flags  - registered flags {O, C, Z, N}

module alu_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   sel,
  input  logic [N-1:0] aIn,
  input  logic [N-1:0] bIn,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] cOut,
  output logic [3:0]   Flags
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  localparam int              CW       = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
  // N always fits in N bits for N >= 2; used as the shift saturation limit.
  localparam logic [N-1:0]    N_LIM    = N'(N);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  // Mul: {high partial sum, remaining multiplier bits}.
  // Div/mod: {partial remainder, dividend bits shifting into quotient}.
  logic [2*N-1:0]   acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     c_out_q, c_out_d;
  logic [3:0]       flags_q, flags_d;

  // Single-cycle datapath, evaluated straight from the inputs.
  logic [N:0]       sc_sum;
  logic [N-1:0]     sc_dif;
  logic [N-1:0]     sc_res;
  logic             sc_o, sc_c, sc_n;
  logic [3:0]       sc_flags;
  logic             is_multi;

  // One iteration of each multi-cycle algorithm.
  logic [N:0]       mul_sum;
  logic [2*N-1:0]   mul_next;
  logic [N:0]       rem_sh;
  logic [N-1:0]     div_sub;
  logic [2*N-1:0]   div_next;

  logic [N-1:0]     fin_res;
  logic             fin_o, fin_c;

  always_comb begin
    sc_sum = {1'b0, aIn} + {1'b0, bIn};
    sc_dif = aIn - bIn;
    sc_res = '0;
    sc_o   = 1'b0;
    sc_c   = 1'b0;
    sc_n   = 1'b0;
    case (sel)
      OP_ADD: begin
        sc_res = sc_sum[N-1:0];
        sc_c   = sc_sum[N];
        sc_o   = (aIn[N-1] == bIn[N-1]) && (sc_sum[N-1] != aIn[N-1]);
      end
      OP_SUB: begin
        sc_res = sc_dif;
        sc_n   = (aIn < bIn);
        sc_o   = (aIn[N-1] != bIn[N-1]) && (sc_dif[N-1] != aIn[N-1]);
      end
      OP_OR:  sc_res = aIn | bIn;
      OP_AND: sc_res = aIn & bIn;
      OP_XOR: sc_res = aIn ^ bIn;
      OP_SHL: sc_res = (bIn >= N_LIM) ? '0 : (aIn << bIn);
      OP_SHR: sc_res = (bIn >= N_LIM) ? '0 : (aIn >> bIn);
      default: sc_res = '0;
    endcase
    sc_flags = {sc_o, sc_c, (sc_res == '0), sc_n};
    is_multi = (sel == OP_MUL) || (sel == OP_DIV) || (sel == OP_MOD);
  end

  always_comb begin
    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole accumulator right.
    mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc_q[N-1:1]};

    // Restoring division: bring down the next dividend bit, subtract the
    // divisor if it fits. A zero divisor always "fits", which naturally
    // yields an all-ones quotient and a remainder equal to A.
    rem_sh  = {acc_q[2*N-1:N], acc_q[N-1]};
    div_sub = rem_sh[N-1:0] - b_q;
    if (rem_sh >= {1'b0, b_q}) begin
      div_next = {div_sub, acc_q[N-2:0], 1'b1};
    end else begin
      div_next = {rem_sh[N-1:0], acc_q[N-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    c_out_d = c_out_q;
    flags_d = flags_q;
    fin_res = '0;
    fin_o   = 1'b0;
    fin_c   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (is_multi) begin
            state_d = EXEC;
            op_d    = sel;
            a_d     = aIn;
            b_d     = bIn;
            cnt_d   = '0;
            acc_d   = (sel == OP_MUL) ? {{N{1'b0}}, bIn} : {{N{1'b0}}, aIn};
          end else begin
            state_d = DONE;
            c_out_d = sc_res;
            flags_d = sc_flags;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        acc_d = (op_q == OP_MUL) ? mul_next : div_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          case (op_q)
            OP_MUL: begin
              fin_res = mul_next[N-1:0];
              fin_c   = |mul_next[2*N-1:N];
            end
            OP_DIV: begin
              fin_res = div_next[N-1:0];
              fin_o   = (b_q == '0);
            end
            default: begin
              fin_res = div_next[2*N-1:N];
              fin_o   = (b_q == '0);
            end
          endcase
          c_out_d = fin_res;
          flags_d = {fin_o, fin_c, (fin_res == '0), 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      c_out_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      c_out_q <= c_out_d;
      flags_q <= flags_d;
    end
  end

  assign busy  = (state_q == EXEC);
  assign done  = (state_q == DONE);
  assign cOut  = c_out_q;
  assign Flags = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (N=8)

module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] sel;
  logic [7:0] aIn;
  logic [7:0] bIn;
  logic       busy;
  logic       done;
  logic [7:0] cOut;
  logic [3:0] Flags;

  int         n_checks = 0;
  int         n_fails  = 0;
  logic [11:0] sb_q[$];
  logic [7:0] last_c = 8'h00;
  logic [3:0] last_f = 4'h0;

  alu_seq #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sel   (sel),
    .aIn   (aIn),
    .bIn   (bIn),
    .busy  (busy),
    .done  (done),
    .cOut  (cOut),
    .Flags (Flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: {cOut, O, C, Z, N}
  function automatic logic [11:0] model(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
    int ia;
    int ib;
    int sa;
    int sb;
    int r;
    int sr;
    bit o;
    bit c;
    bit n;
    logic [7:0] res;
    ia = a;
    ib = b;
    sa = $signed(a);
    sb = $signed(b);
    r  = 0;
    o  = 1'b0;
    c  = 1'b0;
    n  = 1'b0;
    case (s)
      4'd0: begin r = ia + ib; c = (r > 255); sr = sa + sb; o = (sr > 127) || (sr < -128); end
      4'd1: begin r = ia - ib; n = (ia < ib); sr = sa - sb; o = (sr > 127) || (sr < -128); end
      4'd2: begin r = ia * ib; c = (r > 255); end
      4'd3: begin if (ib == 0) begin r = 255; o = 1'b1; end else r = ia / ib; end
      4'd4: begin if (ib == 0) begin r = ia; o = 1'b1; end else r = ia % ib; end
      4'd5: r = ia | ib;
      4'd6: r = ia & ib;
      4'd7: r = ia ^ ib;
      4'd8: r = (ib >= 8) ? 0 : (ia << ib);
      4'd9: r = (ib >= 8) ? 0 : (ia >> ib);
      default: r = 0;
    endcase
    res = r[7:0];
    return {res, o, c, (res == 8'h00), n};
  endfunction

  // Called at a negedge with the DUT able to accept. Returns at the negedge of
  // the done cycle so a following call exercises back-to-back acceptance.
  task automatic do_op(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                       input logic [11:0] exp, input bit poke);
    int lat;
    logic [11:0] exp_v;
    lat   = (s == 4'd2 || s == 4'd3 || s == 4'd4) ? 9 : 1;
    start = 1'b1;
    sel   = s;
    aIn   = a;
    bIn   = b;
    sb_q.push_back(exp);
    @(posedge clk);
    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        sel   = 4'($urandom);
        aIn   = 8'($urandom);
        bIn   = 8'($urandom);
      end
      if (poke) begin
        if (cyc == 3) begin
          start = 1'b1;
          sel   = 4'd6;
          aIn   = 8'h0F;
          bIn   = 8'h33;
        end else if (cyc == 4) begin
          start = 1'b0;
        end
      end
      check("busy", busy, (cyc < lat));
      check("done", done, (cyc == lat));
      if (cyc < lat) check("hold_cOut_busy", cOut, last_c);
      if (done) begin
        check("sb_nonempty", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          exp_v = sb_q.pop_front();
          check("cOut", cOut, exp_v[11:4]);
          check("Flags", Flags, exp_v[3:0]);
          last_c = exp_v[11:4];
          last_f = exp_v[3:0];
        end
      end
    end
    check("sb_drained", sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check("hold_cOut", cOut, last_c);
      check("hold_Flags", Flags, last_f);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rs;
    logic [7:0] ra;
    logic [7:0] rb;

    rst_n = 1'b0;
    start = 1'b0;
    sel   = 4'd0;
    aIn   = 8'h00;
    bIn   = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("rst_cOut", cOut, 0);
    check("rst_Flags", Flags, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // First start on the first edge after release.
    rst_n = 1'b1;
    do_op(4'd0, 8'd200, 8'd100, 12'h2C4, 1'b0);
    idle(2);
    do_op(4'd1, 8'd5,   8'd7,   12'hFE1, 1'b0);
    idle(1);
    do_op(4'd2, 8'd15,  8'd17,  12'hFF0, 1'b0);
    idle(1);
    do_op(4'd2, 8'd16,  8'd16,  12'h006, 1'b0);
    idle(1);
    do_op(4'd3, 8'd200, 8'd7,   12'h1C0, 1'b0);
    idle(1);
    do_op(4'd4, 8'd200, 8'd7,   12'h040, 1'b0);
    idle(1);
    do_op(4'd3, 8'd9,   8'd0,   12'hFF8, 1'b0);
    idle(1);
    do_op(4'd4, 8'd9,   8'd0,   12'h098, 1'b0);
    idle(1);

    // Start during busy must be dropped.
    do_op(4'd2, 8'd15,  8'd17,  12'hFF0, 1'b1);
    idle(2);

    // Reset in cycle 4 of a divide.
    start = 1'b1;
    sel   = 4'd3;
    aIn   = 8'd200;
    bIn   = 8'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check("rstdiv_busy", busy, 1);
      @(negedge clk);
    end
    check("rstdiv_busy4", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rstdiv_cOut", cOut, 0);
    check("rstdiv_Flags", Flags, 0);
    check("rstdiv_busy_low", busy, 0);
    check("rstdiv_done_low", done, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    last_c = 8'h00;
    last_f = 4'h0;
    idle(12);
    do_op(4'd0, 8'd1, 8'd1, 12'h020, 1'b0);
    idle(1);

    // Back-to-back, second start in the DONE cycle.
    do_op(4'd7, 8'hF0, 8'hFF, 12'h0F0, 1'b0);
    do_op(4'd8, 8'h01, 8'd9,  12'h002, 1'b0);
    idle(1);

    // Boundary and flag corners.
    do_op(4'hC, 8'h55, 8'hAA, 12'h002, 1'b0);
    do_op(4'd9, 8'h80, 8'd7,  12'h010, 1'b0);
    do_op(4'd8, 8'h01, 8'd8,  12'h002, 1'b0);
    do_op(4'd8, 8'h81, 8'd1,  12'h020, 1'b0);
    do_op(4'd9, 8'hFF, 8'd8,  12'h002, 1'b0);
    do_op(4'd0, 8'h7F, 8'h01, 12'h808, 1'b0);
    do_op(4'd1, 8'h80, 8'h01, 12'h7F8, 1'b0);
    idle(1);

    // Random operations against the model, sometimes back-to-back.
    for (int i = 0; i < 16; i++) begin
      rs = 4'($urandom_range(0, 11));
      ra = 8'($urandom);
      rb = (rs >= 4'd8) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      do_op(rs, ra, rb, model(rs, ra, rb), 1'b0);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning operand/result width in bits (N >= 2).
REQ-002 The block SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port start  input  1  request to launch an operation.
REQ-005 The block SHALL have port sel  input  4  opcode: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 mod, 0101 or, 0110 and, 0111 xor, 1000 shl, 1001 shr.
REQ-006 The block SHALL have port aIn  input  N  operand A, unsigned.
REQ-007 The block SHALL have port bIn  input  N  operand B, unsigned.
REQ-008 The block SHALL have port busy  output  1  operation in progress; start is ignored.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse; cOut/Flags are new.
REQ-010 The block SHALL have port cOut  output  N  registered result.
REQ-011 The block SHALL have port Flags  output  4  registered flags [3]=O, [2]=C, [1]=Z, [0]=N.

Function
REQ-012 Cycle 0 is the cycle in which start is sampled high while busy=0; sel, aIn and bIn SHALL be captured at that edge and later input changes SHALL NOT affect the operation.
REQ-013 FSM states SHALL be IDLE, EXEC, DONE: IDLE/DONE --start, single-cycle op--> DONE; IDLE/DONE --start, mul/div/mod--> EXEC; EXEC --iteration N complete--> DONE; DONE --no start--> IDLE.
REQ-014 Single-cycle ops (add, sub, or, and, xor, shl, shr, invalid sel) SHALL write cOut/Flags at the end of cycle 0 and assert done in cycle 1; busy SHALL stay 0.
REQ-015 mul SHALL use iterative shift-add, one partial product per cycle; div/mod SHALL use restoring division, one quotient bit per cycle.
REQ-016 Multi-cycle ops SHALL assert busy in cycles 1..N, write cOut/Flags at the end of cycle N, and assert done in cycle N+1 only.
REQ-017 start high in the DONE cycle SHALL be accepted (back-to-back); start while busy=1 SHALL be dropped without effect.
REQ-018 cOut and Flags SHALL hold their values between done pulses.
REQ-019 add: cOut = (A+B) mod 2^N; C = carry out; O = two's-complement signed overflow.
REQ-020 sub: cOut = (A-B) mod 2^N; N = 1 iff A < B unsigned; O = two's-complement signed overflow.
REQ-021 mul: cOut = low N bits of the 2N-bit product; C = 1 iff the high N bits are nonzero.
REQ-022 div: cOut = floor(A/B); mod: cOut = A mod B; B = 0 SHALL give cOut all ones (div) or A (mod), with O = 1 and full N-cycle latency.
REQ-023 shl/shr: logical shift of A by B; B >= N SHALL give cOut = 0.
REQ-024 Z SHALL equal (cOut == 0) over all N bits for every opcode; flags not defined above for an opcode SHALL be 0.
REQ-025 sel 1010..1111 SHALL produce cOut = 0, Flags = 0010, single-cycle latency.

Reset
REQ-026 rst_n low SHALL asynchronously force the state to IDLE, busy=0, done=0, cOut=0, Flags=0000, and clear iteration counters/partial registers.
REQ-027 Reset asserted mid-EXEC SHALL abort the operation; no done pulse SHALL follow deassertion.
REQ-028 The first start SHALL be accepted in the first rising edge after rst_n is released.

Verification (N=8)
REQ-029 add 200+100 -> done in cycle 1, cOut=0x2C, Flags=0100; sub 5-7 -> cOut=0xFE, Flags=0001.
REQ-030 mul 15*17 -> busy cycles 1..8, done in cycle 9, cOut=0xFF, Flags=0000; mul 16*16 -> cOut=0x00, Flags=0110.
REQ-031 div 200/7 -> cOut=28, done in cycle 9; mod 200/7 -> cOut=4; div 9/0 -> cOut=0xFF, Flags=1000.
REQ-032 Start mul, second start (and, new operands) in cycle 3 -> dropped; result still the mul result in cycle 9.
REQ-033 rst_n low in cycle 4 of div -> outputs 0 immediately, no done after release; next add 1+1 -> cOut=2 in cycle 1.
REQ-034 Back-to-back: xor 0xF0^0xFF then shl 0x01<<9 started in the DONE cycle -> cOut=0x0F then cOut=0x00, Flags=0010, done high in consecutive cycles.
